boss_damage_ctl: RTL and testbench

- Boss-side receiver for the player weapon hit interface.
- Consumes the `melee_hit` and `projectile_hit` strobes produced by the weapon subsystem and maintains boss hit points.
- Applies invulnerability frames and sequences the boss death.
- Drives `boss_alive` back to the weapon, boss-draw and game-state logic, and provides HP and hit-flash outputs for the boss sprite and HP bar.

---
 rtl/boss_damage_ctl.sv | 141 ++++++++++++++
 tb/tb_boss_damage_ctl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boss_damage_ctl.sv
// Boss-side hit receiver: edge-detects weapon hits, applies damage with i-frames,
// and sequences the timed death. Every output comes straight from a register.
module boss_damage_ctl #(
  parameter int unsigned BOSS_MAX_HP   = 200,
  parameter int unsigned MELEE_DMG     = 4,
  parameter int unsigned PROJ_DMG      = 2,
  parameter int unsigned IFRAME_FRAMES = 10,
  parameter int unsigned DEATH_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] game_active,
  input  logic       melee_hit,
  input  logic       projectile_hit,
  output logic       boss_alive,
  output logic [7:0] boss_hp,
  output logic       boss_hit_flash,
  output logic       boss_defeated,
  output logic [2:0] boss_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIVE  = 3'd1,
    S_INVULN = 3'd2,
    S_DYING  = 3'd3,
    S_DEAD   = 3'd4
  } state_t;

  localparam logic [7:0] MAX_HP      = 8'(BOSS_MAX_HP);
  localparam logic [7:0] IFRAME_LAST = 8'(IFRAME_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST  = 8'(DEATH_FRAMES - 1);
  localparam logic [8:0] MELEE_D     = 9'(MELEE_DMG);
  localparam logic [8:0] PROJ_D      = 9'(PROJ_DMG);

  state_t     state;
  logic [7:0] hp;
  logic [7:0] cnt;
  logic       alive;
  logic       flash;
  logic       defeated;
  logic       mel_s, mel_p, prj_s, prj_p;

  logic       mel_ev, prj_ev, in_fight;
  logic [8:0] dmg;
  logic [7:0] hp_next;

  // Inputs are sampled first and compared against their previous sample,
  // so a hit costs one cycle of latency and a held level fires only once.
  assign mel_ev   = mel_s & ~mel_p;
  assign prj_ev   = prj_s & ~prj_p;
  assign in_fight = (game_active == 2'b01);
  assign dmg      = (mel_ev ? MELEE_D : 9'd0) + (prj_ev ? PROJ_D : 9'd0);
  assign hp_next  = (dmg >= {1'b0, hp}) ? 8'd0 : 8'({1'b0, hp} - dmg);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      hp       <= MAX_HP;
      cnt      <= 8'd0;
      alive    <= 1'b0;
      flash    <= 1'b0;
      defeated <= 1'b0;
      mel_s    <= 1'b0;
      mel_p    <= 1'b0;
      prj_s    <= 1'b0;
      prj_p    <= 1'b0;
    end else begin
      mel_s    <= melee_hit;
      mel_p    <= mel_s;
      prj_s    <= projectile_hit;
      prj_p    <= prj_s;
      defeated <= 1'b0;

      // Leaving the fight overrides everything and never counts as a kill.
      if (!in_fight && state != S_IDLE) begin
        state <= S_IDLE;
        hp    <= MAX_HP;
        cnt   <= 8'd0;
        alive <= 1'b0;
        flash <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (in_fight) begin
              state <= S_ALIVE;
              alive <= 1'b1;
            end
          end
          S_ALIVE: begin
            if (mel_ev || prj_ev) begin
              hp  <= hp_next;
              cnt <= 8'd0;
              if (hp_next == 8'd0) begin
                state <= S_DYING;
                alive <= 1'b0;
              end else begin
                state <= S_INVULN;
                flash <= 1'b1;
              end
            end
          end
          S_INVULN: begin
            if (frame_tick) begin
              if (cnt == IFRAME_LAST) begin
                state <= S_ALIVE;
                flash <= 1'b0;
                cnt   <= 8'd0;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          S_DYING: begin
            if (frame_tick) begin
              if (cnt == DEATH_LAST) begin
                state    <= S_DEAD;
                defeated <= 1'b1;
                cnt      <= 8'd0;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          S_DEAD: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign boss_alive     = alive;
  assign boss_hp        = hp;
  assign boss_hit_flash = flash;
  assign boss_defeated  = defeated;
  assign boss_state     = state;

endmodule

// File: tb/tb_boss_damage_ctl.sv
// Bench for boss_damage_ctl: directed vector table, hand-written multi-cycle
// sequences on a small-HP variant, and random stimulus against a countdown model.
module tb_boss_damage_ctl;

  localparam int MAX_HP = 200, MEL = 4, PRJ = 2, IFR = 10, DTH = 60;
  localparam int V_MAX_HP = 15;
  localparam int M_IDLE = 0, M_ALIVE = 1, M_INVULN = 2, M_DYING = 3, M_DEAD = 4;

  logic       clk, rst;
  logic       frame_tick, melee_hit, projectile_hit;
  logic [1:0] game_active;
  logic       boss_alive, boss_hit_flash, boss_defeated;
  logic [7:0] boss_hp;
  logic [2:0] boss_state;

  logic       v_ft, v_mel, v_prj;
  logic [1:0] v_ga;
  logic       v_alive, v_flash, v_def;
  logic [7:0] v_hp;
  logic [2:0] v_state;

  int n_cmp = 0;
  int n_bad = 0;

  boss_damage_ctl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
    .melee_hit(melee_hit), .projectile_hit(projectile_hit),
    .boss_alive(boss_alive), .boss_hp(boss_hp), .boss_hit_flash(boss_hit_flash),
    .boss_defeated(boss_defeated), .boss_state(boss_state)
  );

  boss_damage_ctl #(.BOSS_MAX_HP(V_MAX_HP), .IFRAME_FRAMES(1)) dut_v (
    .clk(clk), .rst(rst), .frame_tick(v_ft), .game_active(v_ga),
    .melee_hit(v_mel), .projectile_hit(v_prj),
    .boss_alive(v_alive), .boss_hp(v_hp), .boss_hit_flash(v_flash),
    .boss_defeated(v_def), .boss_state(v_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input int st, input int hp,
                            input bit al, input bit fl, input bit df);
    check({tag, ".state"},  16'(boss_state),     16'(st));
    check({tag, ".hp"},     16'(boss_hp),        16'(hp));
    check({tag, ".alive"},  16'(boss_alive),     16'(al));
    check({tag, ".flash"},  16'(boss_hit_flash), 16'(fl));
    check({tag, ".defeat"}, 16'(boss_defeated),  16'(df));
  endtask

  task automatic mcyc(input logic [1:0] ga, input bit ft, input bit mel, input bit prj);
    game_active = ga; frame_tick = ft; melee_hit = mel; projectile_hit = prj;
    @(posedge clk); #1;
  endtask

  task automatic vcyc(input logic [1:0] ga, input bit ft, input bit mel, input bit prj);
    v_ga = ga; v_ft = ft; v_mel = mel; v_prj = prj;
    @(posedge clk); #1;
  endtask

  // Reference model: mode plus frames remaining; outputs are derived from the mode.
  int m_mode, m_hp, m_left;
  bit m_def, m_ms, m_mp, m_ps, m_pp;

  task automatic model_reset();
    m_mode = M_IDLE; m_hp = MAX_HP; m_left = 0; m_def = 0;
    m_ms = 0; m_mp = 0; m_ps = 0; m_pp = 0;
  endtask

  task automatic model_step(input logic [1:0] ga, input bit ft, input bit mel, input bit prj);
    bit em, ep;
    int dmg;
    em = m_ms && !m_mp;
    ep = m_ps && !m_pp;
    m_mp = m_ms; m_ms = mel; m_pp = m_ps; m_ps = prj;
    m_def = 0;
    if (ga != 2'b01 && m_mode != M_IDLE) begin
      m_mode = M_IDLE; m_hp = MAX_HP;
    end else begin
      case (m_mode)
        M_IDLE: if (ga == 2'b01) m_mode = M_ALIVE;
        M_ALIVE: if (em || ep) begin
          dmg = (em ? MEL : 0) + (ep ? PRJ : 0);
          m_hp = (m_hp > dmg) ? m_hp - dmg : 0;
          if (m_hp == 0) begin m_mode = M_DYING; m_left = DTH; end
          else begin m_mode = M_INVULN; m_left = IFR; end
        end
        M_INVULN: if (ft) begin
          m_left--;
          if (m_left == 0) m_mode = M_ALIVE;
        end
        M_DYING: if (ft) begin
          m_left--;
          if (m_left == 0) begin m_mode = M_DEAD; m_def = 1; end
        end
        default: ;
      endcase
    end
  endtask

  typedef struct {
    logic [1:0] ga;
    bit ft, mel, prj;
    int st, hp;
    bit al, fl, df;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [1:0] ga, input bit ft, input bit mel, input bit prj,
                              input int st, input int hp, input bit al, input bit fl);
    vec_t v;
    v.ga = ga; v.ft = ft; v.mel = mel; v.prj = prj;
    v.st = st; v.hp = hp; v.al = al; v.fl = fl; v.df = 1'b0;
    tbl.push_back(v);
  endfunction

  initial begin
    int hp_changes;
    logic [7:0] last_hp;
    bit saw_def;
    logic [1:0] r_ga;
    bit r_ft, r_mel, r_prj;

    rst = 1'b1;
    game_active = 2'b00; frame_tick = 0; melee_hit = 0; projectile_hit = 0;
    v_ga = 2'b00; v_ft = 0; v_mel = 0; v_prj = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 check_main("reset", M_IDLE, MAX_HP, 0, 0, 0);

    // Directed table: hit latency, held levels, i-frame length, dropped hits,
    // simultaneous hits, leaving the fight, tick coinciding with a hit.
    add(1, 0, 0, 0, M_ALIVE,  200, 1, 0);
    add(1, 0, 1, 0, M_ALIVE,  200, 1, 0);
    add(1, 0, 1, 0, M_INVULN, 196, 1, 1);
    add(1, 1, 1, 0, M_INVULN, 196, 1, 1);
    add(1, 0, 0, 1, M_INVULN, 196, 1, 1);
    add(1, 0, 0, 0, M_INVULN, 196, 1, 1);
    for (int i = 0; i < 8; i++) add(1, 1, 0, 0, M_INVULN, 196, 1, 1);
    add(1, 1, 0, 0, M_ALIVE,  196, 1, 0);
    add(1, 0, 1, 1, M_ALIVE,  196, 1, 0);
    add(1, 0, 1, 1, M_INVULN, 190, 1, 1);
    add(1, 0, 0, 1, M_INVULN, 190, 1, 1);
    add(1, 0, 0, 0, M_INVULN, 190, 1, 1);
    add(1, 0, 0, 1, M_INVULN, 190, 1, 1);
    add(1, 0, 0, 0, M_INVULN, 190, 1, 1);
    add(0, 0, 0, 0, M_IDLE,   200, 0, 0);
    add(0, 0, 1, 1, M_IDLE,   200, 0, 0);
    add(1, 0, 1, 1, M_ALIVE,  200, 1, 0);
    add(1, 0, 1, 1, M_ALIVE,  200, 1, 0);
    add(1, 1, 1, 0, M_ALIVE,  200, 1, 0);
    add(1, 0, 0, 1, M_ALIVE,  200, 1, 0);
    add(1, 1, 0, 1, M_INVULN, 198, 1, 1);
    for (int i = 0; i < 9; i++) add(1, 1, 0, 0, M_INVULN, 198, 1, 1);
    add(1, 1, 0, 0, M_ALIVE,  198, 1, 0);

    foreach (tbl[i]) begin
      mcyc(tbl[i].ga, tbl[i].ft, tbl[i].mel, tbl[i].prj);
      check_main($sformatf("vec%0d", i), tbl[i].st, tbl[i].hp, tbl[i].al, tbl[i].fl, tbl[i].df);
    end

    // Melee held for 50 cycles: exactly one hp change, i-frames expire meanwhile.
    hp_changes = 0;
    last_hp = boss_hp;
    for (int i = 0; i < 50; i++) begin
      mcyc(1, (i % 4) == 3, 1, 0);
      if (boss_hp != last_hp) hp_changes++;
      last_hp = boss_hp;
      if (i == 1) check("hold.flash_on", 16'(boss_hit_flash), 16'd1);
    end
    check("hold.changes", 16'(hp_changes), 16'd1);
    check_main("hold.end", M_ALIVE, 194, 1, 0, 0);
    mcyc(1, 0, 0, 0);

    // Small-HP variant: saturating kill, full death sequence, reload, async reset.
    vcyc(1, 0, 0, 0);
    check("v.start_state", 16'(v_state), 16'(M_ALIVE));
    check("v.start_hp", 16'(v_hp), 16'(V_MAX_HP));
    for (int pass = 0; pass < 2; pass++) begin
      for (int h = 1; h <= 3; h++) begin
        vcyc(1, 0, 1, 0);
        vcyc(1, 0, 0, 0);
        check($sformatf("v%0d.hit%0d_hp", pass, h), 16'(v_hp), 16'(V_MAX_HP - 4 * h));
        vcyc(1, 1, 0, 0);
        check($sformatf("v%0d.hit%0d_state", pass, h), 16'(v_state), 16'(M_ALIVE));
      end
      vcyc(1, 0, 1, 0);
      vcyc(1, 0, 0, 0);
      check($sformatf("v%0d.kill_hp", pass), 16'(v_hp), 16'd0);
      check($sformatf("v%0d.kill_alive", pass), 16'(v_alive), 16'd0);
      check($sformatf("v%0d.kill_state", pass), 16'(v_state), 16'(M_DYING));
      if (pass == 1) break;
      saw_def = 0;
      for (int t = 0; t < DTH - 1; t++) begin
        vcyc(1, 1, 0, 0);
        if (v_def) saw_def = 1;
      end
      check("v.early_defeat", 16'(saw_def), 16'd0);
      check("v.still_dying", 16'(v_state), 16'(M_DYING));
      vcyc(1, 1, 0, 0);
      check("v.dead_state", 16'(v_state), 16'(M_DEAD));
      check("v.defeat_pulse", 16'(v_def), 16'd1);
      vcyc(1, 0, 0, 0);
      check("v.defeat_end", 16'(v_def), 16'd0);
      check("v.dead_hold", 16'(v_state), 16'(M_DEAD));
      vcyc(0, 0, 0, 0);
      check("v.reload_state", 16'(v_state), 16'(M_IDLE));
      check("v.reload_hp", 16'(v_hp), 16'(V_MAX_HP));
      vcyc(1, 0, 0, 0);
    end
    repeat (5) vcyc(1, 1, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async.state", 16'(v_state), 16'(M_IDLE));
    check("async.hp", 16'(v_hp), 16'(V_MAX_HP));
    check("async.alive", 16'(v_alive), 16'd0);
    check("async.main_hp", 16'(boss_hp), 16'(MAX_HP));

    // Random phase on the default-parameter instance against the model.
    game_active = 2'b00; frame_tick = 0; melee_hit = 0; projectile_hit = 0;
    v_ga = 2'b00; v_ft = 0; v_mel = 0; v_prj = 0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    r_mel = 0; r_prj = 0;
    for (int c = 0; c < 4000; c++) begin
      r_ga  = ($urandom_range(0, 399) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      r_ft  = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 5) == 0) r_mel = ~r_mel;
      if ($urandom_range(0, 2) == 0) r_prj = ~r_prj;
      game_active = r_ga; frame_tick = r_ft; melee_hit = r_mel; projectile_hit = r_prj;
      @(posedge clk);
      model_step(r_ga, r_ft, r_mel, r_prj);
      #1;
      check_main($sformatf("rnd%0d", c), m_mode, m_hp,
                 (m_mode == M_ALIVE || m_mode == M_INVULN), (m_mode == M_INVULN), m_def);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
